// File: rtl/instr_fetch_queue.sv
// Instruction fetch front-end: owns the fetch PC, issues one-outstanding req/ack reads to
// instruction memory and buffers {pc, instr} pairs in a small FIFO drained by the IF/ID stage.
module instr_fetch_queue #(
    parameter int DEPTH = 4,
    parameter int AW    = 32,
    parameter int DW    = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          redirect,
    input  logic [AW-1:0] redirect_pc,
    input  logic          stall,
    output logic          out_valid,
    output logic [DW-1:0] out_instr,
    output logic [AW-1:0] out_pc,
    output logic          mem_req,
    output logic [AW-1:0] mem_addr,
    input  logic          mem_ack,
    input  logic [DW-1:0] mem_rdata
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW:0] DEPTH_L = (CW + 1)'(DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_DROP
    } state_e;

    state_e        state_q,    state_d;
    logic [AW-1:0] fetch_pc_q, fetch_pc_d;
    logic [CW-1:0] count_q,    count_d;
    logic [PW-1:0] wr_ptr_q,   wr_ptr_d;
    logic [PW-1:0] rd_ptr_q,   rd_ptr_d;
    logic          mem_req_q,  mem_req_d;
    logic [AW-1:0] mem_addr_q, mem_addr_d;

    logic [AW-1:0] fifo_pc    [DEPTH];
    logic [DW-1:0] fifo_instr [DEPTH];

    logic          push;
    logic          pop;
    logic [CW:0]   level_after;
    logic          space;

    assign out_valid   = (count_q != '0);
    assign pop         = out_valid & ~stall & ~redirect;
    assign push        = (state_q == ST_WAIT) & mem_ack & ~redirect;
    // Occupancy after this cycle's push/pop; one extra bit so DEPTH itself is representable.
    assign level_after = {1'b0, count_q} + (CW + 1)'(push) - (CW + 1)'(pop);
    assign space       = (level_after < DEPTH_L);

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        count_d    = level_after[CW-1:0];
        wr_ptr_d   = wr_ptr_q + PW'(push);
        rd_ptr_d   = rd_ptr_q + PW'(pop);
        mem_req_d  = mem_req_q;
        mem_addr_d = mem_addr_q;

        if (redirect) begin
            // Flush: push is already suppressed, so aligning rd to wr empties the FIFO.
            count_d    = '0;
            rd_ptr_d   = wr_ptr_q;
            fetch_pc_d = redirect_pc;
        end

        unique case (state_q)
            ST_IDLE: begin
                if (!redirect && space) begin
                    mem_req_d  = 1'b1;
                    mem_addr_d = fetch_pc_q;
                    state_d    = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (redirect) begin
                    // An issued request is never withdrawn; its late ack is swallowed in DROP.
                    if (mem_ack) begin
                        mem_req_d = 1'b0;
                        state_d   = ST_IDLE;
                    end else begin
                        state_d   = ST_DROP;
                    end
                end else if (mem_ack) begin
                    fetch_pc_d = fetch_pc_q + AW'(1);
                    if (space) begin
                        mem_addr_d = fetch_pc_q + AW'(1);
                    end else begin
                        mem_req_d = 1'b0;
                        state_d   = ST_IDLE;
                    end
                end
            end
            ST_DROP: begin
                if (mem_ack) begin
                    mem_req_d = 1'b0;
                    state_d   = ST_IDLE;
                end
            end
            default: begin
                mem_req_d = 1'b0;
                state_d   = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (!rst) begin
            state_q    <= ST_IDLE;
            fetch_pc_q <= '0;
            count_q    <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            mem_req_q  <= 1'b0;
            mem_addr_q <= '0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            count_q    <= count_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            mem_req_q  <= mem_req_d;
            mem_addr_q <= mem_addr_d;
        end
    end

    // NOTE: FIFO storage is deliberately not reset; count gates every read, so stale contents are never visible.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_pc[wr_ptr_q]    <= mem_addr_q;
            fifo_instr[wr_ptr_q] <= mem_rdata;
        end
    end

    assign out_pc    = out_valid ? fifo_pc[rd_ptr_q]    : '0;
    assign out_instr = out_valid ? fifo_instr[rd_ptr_q] : '0;
    assign mem_req   = mem_req_q;
    assign mem_addr  = mem_addr_q;

endmodule

// File: tb/tb_instr_fetch_queue.sv
// Directed bench for instr_fetch_queue: latency-programmable memory model, pop logger and
// hand-derived expectations for reset, streaming, backpressure, redirect and wrap scenarios.
module tb_instr_fetch_queue;

    localparam int DEPTH = 4;
    localparam int AW    = 32;
    localparam int DW    = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic          redirect;
    logic [AW-1:0] redirect_pc;
    logic          stall;
    logic          out_valid;
    logic [DW-1:0] out_instr;
    logic [AW-1:0] out_pc;
    logic          mem_req;
    logic [AW-1:0] mem_addr;
    logic          mem_ack;
    logic [DW-1:0] mem_rdata;

    int n_checks = 0;
    int n_pass   = 0;
    int lat      = 0;
    int age      = 0;
    int base     = 0;
    logic [63:0] pop_log [$];

    instr_fetch_queue #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
        .clk         (clk),
        .rst         (rst),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .stall       (stall),
        .out_valid   (out_valid),
        .out_instr   (out_instr),
        .out_pc      (out_pc),
        .mem_req     (mem_req),
        .mem_addr    (mem_addr),
        .mem_ack     (mem_ack),
        .mem_rdata   (mem_rdata)
    );

    always #5 clk = ~clk;

    function automatic logic [DW-1:0] rom(input logic [AW-1:0] a);
        return 32'h0000_1000 + a;
    endfunction

    function automatic logic [63:0] logged(input int idx);
        if (idx < pop_log.size()) return pop_log[idx];
        return 64'hDEAD_DEAD_DEAD_DEAD;
    endfunction

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    endtask

    // View point: just after the falling edge, when the memory model has decided this cycle's ack.
    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    // Memory: acks once a request has been seen for `lat` full cycles (lat=0 acks in the first cycle).
    initial begin : mem_model
        logic seen;
        mem_ack   = 1'b0;
        mem_rdata = '0;
        forever begin
            @(negedge clk);
            seen = rst && mem_req;
            if (seen && age >= lat) begin
                mem_ack   = 1'b1;
                mem_rdata = rom(mem_addr);
            end else begin
                mem_ack   = 1'b0;
            end
            @(posedge clk);
            #1;
            if (!rst || !seen || mem_ack) age = 0;
            else age++;
            mem_ack = 1'b0;
        end
    end

    // Every accepted pop as {pc, instr}, sampled after the stimulus of the cycle is settled.
    initial begin : pop_monitor
        forever begin
            @(negedge clk);
            #3;
            if (rst && out_valid && !stall && !redirect) pop_log.push_back({out_pc, out_instr});
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        logic [AW-1:0] exp_pc;
        rst = 1'b0; redirect = 1'b0; redirect_pc = '0; stall = 1'b0; lat = 0;

        // Reset state and first request.
        tick(); tick();
        check("rst_mem_req",   mem_req,   0);
        check("rst_mem_addr",  mem_addr,  0);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_pc",    out_pc,    0);
        check("rst_out_instr", out_instr, 0);
        rst = 1'b1;
        tick();
        check("first_req",      mem_req,   1);
        check("first_addr",     mem_addr,  0);
        check("first_no_valid", out_valid, 0);

        // Zero-latency streaming: one instruction per cycle, no bubbles.
        for (int i = 0; i < 7; i++) begin
            tick();
            check("stream_valid", out_valid, 1);
            check("stream_pc",    out_pc,    i);
            check("stream_instr", out_instr, 32'h1000 + i);
        end

        // Backpressure: restart at 0 and stall long enough to fill the FIFO.
        redirect = 1'b1; redirect_pc = 32'h0; stall = 1'b1;
        tick();
        redirect = 1'b0;
        check("bp_flush_valid", out_valid, 0);
        repeat (10) tick();
        check("bp_full_req_low", mem_req,   0);
        check("bp_head_valid",   out_valid, 1);
        check("bp_head_pc",      out_pc,    0);
        check("bp_head_instr",   out_instr, 32'h1000);
        base  = pop_log.size();
        stall = 1'b0;
        repeat (12) tick();
        for (int i = 0; i < 6; i++) begin
            check("bp_order_pc",    logged(base + i) >> 32,  i);
            check("bp_order_instr", logged(base + i) & 64'hFFFF_FFFF, 32'h1000 + i);
        end

        // Redirect while a request is in flight (latency 3): stale ack must be dropped.
        lat = 3; redirect = 1'b1; redirect_pc = 32'h20;
        tick();
        redirect = 1'b0;
        for (int i = 0; i < 20 && !(mem_req && mem_addr == 32'h21); i++) tick();
        check("rf_req2_addr", mem_addr, 32'h21);
        tick();
        check("rf_no_ack_yet", mem_ack, 0);
        redirect = 1'b1; redirect_pc = 32'h40; base = pop_log.size();
        tick();
        redirect = 1'b0;
        check("rf_flush_valid", out_valid, 0);
        check("rf_drop_req",    mem_req,   1);
        check("rf_drop_addr",   mem_addr,  32'h21);
        for (int i = 0; i < 30 && !out_valid; i++) tick();
        check("rf_next_pc",    out_pc,    32'h40);
        check("rf_next_instr", out_instr, 32'h1040);
        tick();
        check("rf_first_pop", logged(base) >> 32, 32'h40);

        // Redirect on the same edge as an ack: acked data is discarded.
        stall = 1'b1;
        for (int i = 0; i < 12 && !mem_ack; i++) tick();
        check("co_ack_seen", mem_ack, 1);
        redirect = 1'b1; redirect_pc = 32'h80;
        tick();
        redirect = 1'b0;
        check("co_flush_valid", out_valid, 0);
        check("co_idle_req",    mem_req,   0);
        tick();
        check("co_new_req",  mem_req,  1);
        check("co_new_addr", mem_addr, 32'h80);
        stall = 1'b0;
        for (int i = 0; i < 20 && !out_valid; i++) tick();
        check("co_next_pc", out_pc, 32'h80);

        // Address wrap with intermittent stall (pointer wrap after >8 pushes).
        lat = 0; redirect = 1'b1; redirect_pc = 32'hFFFF_FFFF; base = pop_log.size();
        tick();
        redirect = 1'b0;
        for (int i = 0; i < 24; i++) begin
            stall = (i % 3 == 1);
            tick();
        end
        stall = 1'b0;
        repeat (8) tick();
        for (int i = 0; i < 12; i++) begin
            exp_pc = 32'hFFFF_FFFF + 32'(i);
            check("wrap_pc",    logged(base + i) >> 32,  exp_pc);
            check("wrap_instr", logged(base + i) & 64'hFFFF_FFFF, rom(exp_pc));
        end

        // Asynchronous reset in the middle of a WAIT with a buffered entry.
        stall = 1'b1; lat = 20;
        for (int i = 0; i < 12 && !(mem_req && out_valid); i++) tick();
        check("rm_pre_req",   mem_req,   1);
        check("rm_pre_valid", out_valid, 1);
        rst = 1'b0;
        #1;
        check("rm_mem_req",   mem_req,   0);
        check("rm_mem_addr",  mem_addr,  0);
        check("rm_out_valid", out_valid, 0);
        check("rm_out_pc",    out_pc,    0);
        check("rm_out_instr", out_instr, 0);
        tick();
        rst = 1'b1; stall = 1'b0;
        tick();
        check("rm_restart_req",   mem_req,   1);
        check("rm_restart_addr",  mem_addr,  0);
        check("rm_restart_valid", out_valid, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/instr_fetch_queue.md
# instr_fetch_queue

Instruction fetch front-end that sits directly upstream of the IF/ID pipeline register. It owns the fetch PC and issues word-addressed read requests to instruction memory over a req/ack handshake that tolerates variable latency. Returned instructions are buffered with their PCs in a small FIFO that the IF/ID stage drains under hazard-unit stall control. A branch/jump redirect flushes the FIFO and squashes any in-flight fetch.

## Interface
- DEPTH, 4, FIFO entries; power of two, at least 2
- AW, 32, PC / memory address width (word address; sequential PC increments by 1)
- DW, 32, instruction width
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-low reset
- redirect  in  1  one-cycle pulse: branch/jump taken; flush and restart fetch
- redirect_pc  in  AW  new fetch PC, sampled when redirect=1
- stall  in  1  IF/ID not accepting this cycle (from hazard detection unit)
- out_valid  out  1  head entry valid
- out_instr  out  DW  head instruction
- out_pc  out  AW  PC of head instruction
- mem_req  out  1  read request to instruction memory
- mem_addr  out  AW  request address; stable while mem_req=1
- mem_ack  in  1  one-cycle pulse: mem_rdata valid, request completed
- mem_rdata  in  DW  instruction data

## Operation
- State: fetch_pc, FIFO (DEPTH × {pc, instr}), count (0..DEPTH), FSM IDLE / WAIT / DROP.
- Pop = out_valid & ~stall & ~redirect. Push = mem_ack in WAIT with no redirect that cycle.
- out_valid = (count != 0); out_instr/out_pc show the head entry, zero when empty.
- Space test: count + push − pop < DEPTH. At most one request outstanding, so the FIFO never overflows.
- IDLE: if space and no redirect, then mem_req<=1, mem_addr<=fetch_pc, go WAIT.
- WAIT: mem_req and mem_addr held until mem_ack. On ack:
  - push {mem_addr, mem_rdata}; fetch_pc<=fetch_pc+1;
  - if space remains, mem_addr<=fetch_pc+1 and stay WAIT with mem_req=1 (back-to-back);
  - otherwise mem_req<=0 and go IDLE.
- Redirect has top priority in every state:
  - count<=0; fetch_pc<=redirect_pc; any pop that cycle is void.
  - IDLE, or WAIT with mem_ack the same cycle: discard any rdata and go IDLE with mem_req<=0.
  - WAIT without ack: go DROP. mem_req stays high with the old address; a request is never withdrawn.
  - DROP + redirect: update fetch_pc only and stay DROP.
- DROP: on mem_ack, discard data, mem_req<=0, go IDLE. Nothing is pushed.
- Address arithmetic wraps modulo 2^AW (0xFFFFFFFF+1 = 0).
- FIFO pointers are log2(DEPTH) bits and wrap naturally. count is log2(DEPTH)+1 bits.

## Timing
- Reset (rst=0, async): state IDLE, fetch_pc=0, count=0, FIFO pointers 0, mem_req=0, mem_addr=0, out_valid=0, out_instr=0, out_pc=0. Applies immediately, mid-transaction included. Any ack still pending is ignored after reset.
- First mem_req (addr 0) rises at the first clk edge after rst deasserts.
- mem_ack may arrive in the same cycle as the request is first seen, or any number of cycles later.
- Ack at edge k: entry is visible at out_valid/out_instr from cycle k+1. With zero-wait memory the block sustains 1 instruction per cycle.
- Redirect at edge r: out_valid=0 from r+1. The new-PC request is asserted at r+1 if the FSM returns to IDLE at r. From DROP it is asserted one cycle after the dropping ack.
- Pop and push in the same cycle: count is unchanged and ordering is preserved.
- All outputs are registered except out_valid, out_instr and out_pc, which decode from registered FIFO state.

## Test plan
- Reset: rst=0 mid-WAIT with mem_req=1 → all outputs 0 immediately. After release, mem_req=1 with mem_addr=0 on the next edge.
- Streaming: zero-latency ack, ROM[i]=0x1000+i, stall=0 → out_pc 0,1,2,… on consecutive cycles with out_instr 0x1000,0x1001,…, no bubbles after the first.
- Backpressure: stall=1 for 10 cycles → count saturates at 4, mem_req drops to 0, no entry lost. After stall=0, PCs 0..5 appear in order.
- Redirect in flight: ack latency 3, redirect to 0x40 one cycle after request 2 is issued → stale ack discarded (DROP). The next out_pc is 0x40 and the stale instruction never appears.
- Redirect coincident with ack: redirect_pc=0x80 on the same edge as mem_ack → acked data dropped, count=0. Next mem_addr=0x80.
- Wrap: redirect_pc=0xFFFFFFFF → fetches 0xFFFFFFFF then 0x00000000. FIFO pointer wrap is exercised by more than 8 pushes with intermittent stall.
